// File: rtl/mips_mc_controller_if.sv
// Control-unit bundle between the instruction register, multicycle datapath and unified memory.
// master = controller side (drives control strobes), slave = datapath/memory side.
interface mips_mc_controller_if #(
    parameter int OP_W     = 6,
    parameter int FUNCT_W  = 6,
    parameter int ALUCTL_W = 3
);
    logic [OP_W-1:0]     i_op_w;
    logic [FUNCT_W-1:0]  i_funct_w;
    logic                i_zero_w;
    logic                i_mem_ready_w;
    logic                o_mem_req_w;
    logic                o_mem_write_w;
    logic                o_iord_w;
    logic                o_ir_write_w;
    logic                o_pc_write_w;
    logic [1:0]          o_pc_src_w;
    logic                o_alu_src_a_w;
    logic [1:0]          o_alu_src_b_w;
    logic                o_reg_dst_w;
    logic                o_mem_to_reg_w;
    logic                o_reg_write_w;
    logic [ALUCTL_W-1:0] o_alu_control_w;
    logic [1:0]          o_fault_w;
    logic [3:0]          o_state_w;

    modport master (
        input  i_op_w, i_funct_w, i_zero_w, i_mem_ready_w,
        output o_mem_req_w, o_mem_write_w, o_iord_w, o_ir_write_w, o_pc_write_w,
               o_pc_src_w, o_alu_src_a_w, o_alu_src_b_w, o_reg_dst_w, o_mem_to_reg_w,
               o_reg_write_w, o_alu_control_w, o_fault_w, o_state_w
    );

    modport slave (
        output i_op_w, i_funct_w, i_zero_w, i_mem_ready_w,
        input  o_mem_req_w, o_mem_write_w, o_iord_w, o_ir_write_w, o_pc_write_w,
               o_pc_src_w, o_alu_src_a_w, o_alu_src_b_w, o_reg_dst_w, o_mem_to_reg_w,
               o_reg_write_w, o_alu_control_w, o_fault_w, o_state_w
    );
endinterface

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS Moore control FSM; optional bne/slti decode under MIPS_MC_EXT_OPS_EN.
// Latency: outputs decode combinationally from the state register (ir/pc write also see ready/zero).
// Backpressure: memory states hold mem_req until ready; bounded by MEM_TIMEOUT, then sticky fault.
module mips_mc_controller #(
    parameter int OP_W        = 6,
    parameter int FUNCT_W     = 6,
    parameter int ALUCTL_W    = 3,
    parameter int MEM_TIMEOUT = 15,
    parameter int WAIT_CNT_W  = 4
) (
    input  logic                  i_clk_w,
    input  logic                  i_rst_w,
    mips_mc_controller_if.master  bus
);
    typedef enum logic [3:0] {
        S_RST_IDLE = 4'd0,  S_FETCH  = 4'd1,  S_DECODE  = 4'd2,  S_MEMADR = 4'd3,
        S_MEMRD    = 4'd4,  S_MEMWB  = 4'd5,  S_MEMWR   = 4'd6,  S_EXECUTE = 4'd7,
        S_ALUWB    = 4'd8,  S_BRANCH = 4'd9,  S_IMMEXEC = 4'd10, S_IMMWB  = 4'd11,
        S_JUMP     = 4'd12, S_FAULT  = 4'd15
    } state_e;

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
`ifdef MIPS_MC_EXT_OPS_EN
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
    localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(6'b001010);
`endif
    localparam logic [FUNCT_W-1:0] F_ADD = FUNCT_W'(6'b100000);
    localparam logic [FUNCT_W-1:0] F_SUB = FUNCT_W'(6'b100010);
    localparam logic [FUNCT_W-1:0] F_AND = FUNCT_W'(6'b100100);
    localparam logic [FUNCT_W-1:0] F_OR  = FUNCT_W'(6'b100101);
    localparam logic [FUNCT_W-1:0] F_SLT = FUNCT_W'(6'b101010);

    localparam logic [ALUCTL_W-1:0] ALU_AND = ALUCTL_W'(3'b000);
    localparam logic [ALUCTL_W-1:0] ALU_OR  = ALUCTL_W'(3'b001);
    localparam logic [ALUCTL_W-1:0] ALU_ADD = ALUCTL_W'(3'b010);
    localparam logic [ALUCTL_W-1:0] ALU_SUB = ALUCTL_W'(3'b110);
    localparam logic [ALUCTL_W-1:0] ALU_SLT = ALUCTL_W'(3'b111);

    state_e                state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_q, wait_d;
    logic [1:0]            fault_q, fault_d;

    logic                mem_req, mem_write, iord, ir_write, pc_write;
    logic [1:0]          pc_src, alu_src_b;
    logic                alu_src_a, reg_dst, mem_to_reg, reg_write;
    logic [ALUCTL_W-1:0] alu_ctl;
    logic                timeout_hit;

    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_q == WAIT_CNT_W'(MEM_TIMEOUT));

    always_ff @(posedge i_clk_w or negedge i_rst_w) begin
        if (!i_rst_w) begin
            state_q <= S_RST_IDLE;
            wait_q  <= '0;
            fault_q <= 2'b00;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        fault_d    = fault_q;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_ctl    = ALU_ADD;

        case (state_q)
            S_RST_IDLE: begin
                alu_ctl = ALU_AND;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                if (bus.i_mem_ready_w) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (bus.i_op_w)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE: begin
                        if (bus.i_funct_w inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT}) begin
                            state_d = S_EXECUTE;
                        end else begin
                            state_d = S_FAULT;
                            fault_d = 2'b10;
                        end
                    end
                    OP_BEQ:  state_d = S_BRANCH;
                    OP_ADDI: state_d = S_IMMEXEC;
                    OP_J:    state_d = S_JUMP;
`ifdef MIPS_MC_EXT_OPS_EN
                    OP_BNE:  state_d = S_BRANCH;
                    OP_SLTI: state_d = S_IMMEXEC;
`endif
                    default: begin
                        state_d = S_FAULT;
                        fault_d = 2'b10;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (bus.i_op_w == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (bus.i_mem_ready_w) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                iord      = 1'b1;
                if (bus.i_mem_ready_w) state_d = S_FETCH;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                case (bus.i_funct_w)
                    F_SUB:   alu_ctl = ALU_SUB;
                    F_AND:   alu_ctl = ALU_AND;
                    F_OR:    alu_ctl = ALU_OR;
                    F_SLT:   alu_ctl = ALU_SLT;
                    default: alu_ctl = ALU_ADD;
                endcase
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctl   = ALU_SUB;
                pc_src    = 2'b01;
                pc_write  = bus.i_zero_w;
`ifdef MIPS_MC_EXT_OPS_EN
                if (bus.i_op_w == OP_BNE) pc_write = ~bus.i_zero_w;
`endif
                state_d = S_FETCH;
            end
            S_IMMEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
`ifdef MIPS_MC_EXT_OPS_EN
                if (bus.i_op_w == OP_SLTI) alu_ctl = ALU_SLT;
`endif
                state_d = S_IMMWB;
            end
            S_IMMWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                state_d  = S_FETCH;
            end
            S_FAULT: state_d = S_FAULT;
            default: begin
                state_d = S_FAULT;
                fault_d = 2'b10;
            end
        endcase

        // Ready in the same cycle as the limit is reached wins over the timeout.
        if (mem_req && !bus.i_mem_ready_w) begin
            wait_d = wait_q + WAIT_CNT_W'(1);
            if (timeout_hit) begin
                state_d = S_FAULT;
                fault_d = 2'b01;
            end
        end
        if ((state_d != state_q) &&
            (state_d == S_FETCH || state_d == S_MEMRD || state_d == S_MEMWR)) begin
            wait_d = '0;
        end
    end

    assign bus.o_mem_req_w     = mem_req;
    assign bus.o_mem_write_w   = mem_write;
    assign bus.o_iord_w        = iord;
    assign bus.o_ir_write_w    = ir_write;
    assign bus.o_pc_write_w    = pc_write;
    assign bus.o_pc_src_w      = pc_src;
    assign bus.o_alu_src_a_w   = alu_src_a;
    assign bus.o_alu_src_b_w   = alu_src_b;
    assign bus.o_reg_dst_w     = reg_dst;
    assign bus.o_mem_to_reg_w  = mem_to_reg;
    assign bus.o_reg_write_w   = reg_write;
    assign bus.o_alu_control_w = alu_ctl;
    assign bus.o_fault_w       = fault_q;
    assign bus.o_state_w       = state_q;
endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for the multicycle controller: walks instruction classes, wait states,
// memory timeout, illegal-op trap and async reset, with hand-computed expectations.
module tb_mips_mc_controller;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    mips_mc_controller_if #(.OP_W(6), .FUNCT_W(6), .ALUCTL_W(3)) bus ();

    mips_mc_controller #(
        .OP_W(6), .FUNCT_W(6), .ALUCTL_W(3), .MEM_TIMEOUT(15), .WAIT_CNT_W(4)
    ) dut (
        .i_clk_w (clk),
        .i_rst_w (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every output concatenated; must be all zero in RST_IDLE.
    function automatic logic [31:0] all_outs();
        return 32'({bus.o_mem_req_w, bus.o_mem_write_w, bus.o_iord_w, bus.o_ir_write_w,
                    bus.o_pc_write_w, bus.o_pc_src_w, bus.o_alu_src_a_w, bus.o_alu_src_b_w,
                    bus.o_reg_dst_w, bus.o_mem_to_reg_w, bus.o_reg_write_w,
                    bus.o_alu_control_w, bus.o_fault_w, bus.o_state_w});
    endfunction

    // Advance one clock; leaves time just after the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // From FETCH: present the instruction with ready=1, go to DECODE, then one more edge.
    task automatic issue(input logic [5:0] op, input logic [5:0] funct);
        bus.i_op_w        = op;
        bus.i_funct_w     = funct;
        bus.i_mem_ready_w = 1'b1;
        #1;
        chk("fetch_state", 32'(bus.o_state_w), 32'd1);
        step();
        chk("decode_state", 32'(bus.o_state_w), 32'd2);
        chk("decode_srcb", 32'(bus.o_alu_src_b_w), 32'd3);
        step();
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.i_op_w        = 6'd0;
        bus.i_funct_w     = 6'd0;
        bus.i_zero_w      = 1'b0;
        bus.i_mem_ready_w = 1'b0;

        // Reset state
        #12;
        chk("reset_outs", all_outs(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_outs", all_outs(), 32'd0);
        step();

        // FETCH waits while ready is low
        chk("fetch_state", 32'(bus.o_state_w), 32'd1);
        chk("fetch_req", 32'({bus.o_mem_req_w, bus.o_iord_w, bus.o_alu_src_a_w, bus.o_alu_src_b_w}), 32'b10001);
        chk("fetch_irw_noready", 32'({bus.o_ir_write_w, bus.o_pc_write_w}), 32'd0);
        step();
        chk("fetch_hold", 32'(bus.o_state_w), 32'd1);
        bus.i_mem_ready_w = 1'b1;
        #1;
        chk("fetch_irw_ready", 32'({bus.o_ir_write_w, bus.o_pc_write_w, bus.o_pc_src_w}), 32'b1100);

        // add: 1,2,7,8,1
        issue(6'b000000, 6'b100000);
        chk("exec_state", 32'(bus.o_state_w), 32'd7);
        chk("exec_src", 32'({bus.o_alu_src_a_w, bus.o_alu_src_b_w, bus.o_alu_control_w}), 32'b100010);
        step();
        chk("aluwb_state", 32'(bus.o_state_w), 32'd8);
        chk("aluwb_ctl", 32'({bus.o_reg_write_w, bus.o_reg_dst_w, bus.o_mem_to_reg_w}), 32'b110);
        step();
        chk("add_back_fetch", 32'(bus.o_state_w), 32'd1);

        // slt funct maps to alu 111
        issue(6'b000000, 6'b101010);
        chk("slt_alu", 32'(bus.o_alu_control_w), 32'b111);
        step();
        step();

        // lw with ready low for 3 cycles in MEMRD
        issue(6'b100011, 6'b000000);
        chk("memadr_state", 32'(bus.o_state_w), 32'd3);
        chk("memadr_src", 32'({bus.o_alu_src_a_w, bus.o_alu_src_b_w}), 32'b110);
        bus.i_mem_ready_w = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            chk("memrd_wait", 32'({bus.o_state_w, bus.o_mem_req_w, bus.o_iord_w, bus.o_mem_write_w}), {25'd0, 4'd4, 3'b110});
            step();
        end
        bus.i_mem_ready_w = 1'b1;
        #1;
        chk("memrd_ready", 32'({bus.o_state_w, bus.o_mem_req_w, bus.o_iord_w}), {26'd0, 4'd4, 2'b11});
        step();
        chk("memwb_state", 32'(bus.o_state_w), 32'd5);
        chk("memwb_ctl", 32'({bus.o_reg_write_w, bus.o_mem_to_reg_w}), 32'b11);
        step();

        // lw: ready arrives exactly when the counter hits the limit -> normal completion
        issue(6'b100011, 6'b000000);
        bus.i_mem_ready_w = 1'b0;
        step();
        for (int i = 0; i < 15; i++) step();
        chk("memrd_edge_state", 32'(bus.o_state_w), 32'd4);
        bus.i_mem_ready_w = 1'b1;
        #1;
        step();
        chk("ready_wins_timeout", 32'({bus.o_state_w, bus.o_fault_w}), {26'd0, 4'd5, 2'b00});
        step();

        // sw with ready stuck low -> FAULT after 16 request cycles
        issue(6'b101011, 6'b000000);
        bus.i_mem_ready_w = 1'b0;
        step();
        for (int i = 0; i < 16; i++) begin
            chk("memwr_wait", 32'({bus.o_state_w, bus.o_mem_req_w, bus.o_mem_write_w, bus.o_iord_w}), {25'd0, 4'd6, 3'b111});
            step();
        end
        chk("timeout_state", 32'(bus.o_state_w), 32'd15);
        chk("timeout_fault", 32'(bus.o_fault_w), 32'b01);
        chk("timeout_nowrite", 32'({bus.o_mem_req_w, bus.o_mem_write_w}), 32'd0);
        bus.i_mem_ready_w = 1'b1;
        step();
        chk("fault_sticky", 32'({bus.o_state_w, bus.o_fault_w}), {26'd0, 4'd15, 2'b01});

        // Async reset
        rst_n = 1'b0;
        #1;
        chk("reset_from_fault", all_outs(), 32'd0);
        rst_n = 1'b1;
        step();

        // beq taken then not taken
        for (int z = 1; z >= 0; z--) begin
            issue(6'b000100, 6'b000000);
            bus.i_zero_w = 1'(z);
            #1;
            chk("branch_state", 32'(bus.o_state_w), 32'd9);
            chk("branch_ctl", 32'({bus.o_pc_write_w, bus.o_pc_src_w, bus.o_alu_control_w, bus.o_alu_src_a_w}),
                32'({1'(z), 2'b01, 3'b110, 1'b1}));
            step();
            chk("branch_back_fetch", 32'(bus.o_state_w), 32'd1);
            bus.i_zero_w = 1'b0;
        end

        // addi -> IMMEXEC, IMMWB
        issue(6'b001000, 6'b000000);
        chk("immexec", 32'({bus.o_state_w, bus.o_alu_src_a_w, bus.o_alu_src_b_w, bus.o_alu_control_w}),
            {23'd0, 4'd10, 1'b1, 2'b10, 3'b010});
        step();
        chk("immwb", 32'({bus.o_state_w, bus.o_reg_write_w, bus.o_reg_dst_w}), {26'd0, 4'd11, 2'b10});
        step();

        // jump
        issue(6'b000010, 6'b000000);
        chk("jump", 32'({bus.o_state_w, bus.o_pc_write_w, bus.o_pc_src_w}), {25'd0, 4'd12, 3'b110});
        step();
        chk("jump_back_fetch", 32'(bus.o_state_w), 32'd1);

        // illegal opcode
        issue(6'b111111, 6'b000000);
        chk("illegal_op", 32'({bus.o_state_w, bus.o_fault_w}), {26'd0, 4'd15, 2'b10});
        rst_n = 1'b0;
        #1;
        chk("reset_after_illegal", all_outs(), 32'd0);
        rst_n = 1'b1;
        step();

        // bne with zero=0
        bus.i_zero_w = 1'b0;
        issue(6'b000101, 6'b000000);
`ifdef MIPS_MC_EXT_OPS_EN
        chk("bne_taken", 32'({bus.o_state_w, bus.o_pc_write_w}), {27'd0, 4'd9, 1'b1});
`else
        chk("bne_illegal", 32'({bus.o_state_w, bus.o_fault_w}), {26'd0, 4'd15, 2'b10});
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
